// File: rtl/edge_pe_fv_rx_pkg.sv
// Shared types and sizes for the edge PE feature-vector receiver.
// Optional protocol checker is enabled with FV_RX_ERRCHK_EN.
`ifndef Max_FV_num
`define Max_FV_num 16
`endif
`ifndef Num_Edge_PE
`define Num_Edge_PE 4
`endif
`ifndef FV_bandwidth
`define FV_bandwidth 16
`endif

package edge_pe_fv_rx_pkg;

  localparam int MAX_FV = `Max_FV_num;
  localparam int NUM_PE = `Num_Edge_PE;
  localparam int FV_BW  = `FV_bandwidth;
  localparam int TAG_W  = $clog2(NUM_PE);
  localparam int IDX_W  = $clog2(MAX_FV);
  localparam int LEN_W  = IDX_W + 1;

  typedef struct packed {
    logic             valid;
    logic             sos;
    logic             eos;
    logic [TAG_W-1:0] PE_tag;
    logic [FV_BW-1:0] FV_data;
  } FV_bank_CNTL2Edge_PE;

  // Two features per stream word, rounded up.
  function automatic logic [LEN_W:0] words_for(input logic [LEN_W-1:0] n);
    return ({1'b0, n} + (LEN_W+1)'(1)) >> 1;
  endfunction

endpackage

// File: rtl/fv_rx_buf.sv
// Byte-addressed feature buffer: two-byte write, one async read.
// Contents are never reset; out-of-range writes are dropped.
module fv_rx_buf
  import edge_pe_fv_rx_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [LEN_W:0]   widx,
  input  logic [FV_BW-1:0] wdata,
  input  logic             hi_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0]     mem [MAX_FV];
  logic [LEN_W:0] hidx;
  logic           lo_ok;
  logic           hi_ok;

  assign hidx  = widx + (LEN_W+1)'(1);
  assign lo_ok = widx < (LEN_W+1)'(MAX_FV);
  assign hi_ok = hidx < (LEN_W+1)'(MAX_FV);

  always_ff @(posedge clk) begin
    if (we && lo_ok)
      mem[widx[IDX_W-1:0]] <= wdata[7:0];
    if (we && hi_en && hi_ok)
      mem[hidx[IDX_W-1:0]] <= wdata[15:8];
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/edge_pe_fv_rx.sv
// Edge PE feature-vector receiver: tag filter, IDLE/RECV/FULL FSM.
// Define FV_RX_ERRCHK_EN to build the sticky protocol checker.
module edge_pe_fv_rx
  import edge_pe_fv_rx_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [TAG_W-1:0]    my_tag,
  input  FV_bank_CNTL2Edge_PE fv_in,
  input  logic [LEN_W-1:0]    num_fv,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [7:0]          rd_data,
  output logic                fv_valid,
  output logic [LEN_W-1:0]    fv_len,
  input  logic                fv_release,
  output logic                rx_ready,
  output logic                rx_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len;

  logic             accept;
  logic             sos;
  logic             eos;
  logic [LEN_W-1:0] wbase;
  logic [LEN_W-1:0] lenv;
  logic [LEN_W:0]   widx;
  logic [LEN_W-1:0] cnt_next;
  logic             hi_en;
  logic             we;

  assign accept = fv_in.valid && (fv_in.PE_tag == my_tag);
  assign sos    = fv_in.sos;
  assign eos    = fv_in.eos;

  // An sos word always lands at word 0, even mid-vector.
  assign wbase    = sos ? '0 : cnt;
  assign lenv     = sos ? num_fv : len;
  assign widx     = {wbase, 1'b0};
  assign hi_en    = (widx + (LEN_W+1)'(1)) < {1'b0, lenv};
  assign cnt_next = (&wbase) ? wbase : wbase + LEN_W'(1);
  assign we       = accept &&
                    ((state == IDLE && sos) || state == RECV);

  fv_rx_buf u_buf (
    .clk     (clk),
    .we      (we),
    .widx    (widx),
    .wdata   (fv_in.FV_data),
    .hi_en   (hi_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      fv_valid <= 1'b0;
      rx_ready <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && sos) begin
            len      <= num_fv;
            cnt      <= cnt_next;
            rx_ready <= 1'b0;
            if (eos) begin
              state    <= FULL;
              fv_valid <= 1'b1;
            end else begin
              state <= RECV;
            end
          end
        end
        RECV: begin
          if (accept) begin
            if (sos)
              len <= num_fv;
            cnt <= cnt_next;
            if (eos) begin
              state    <= FULL;
              fv_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          if (fv_release) begin
            state    <= IDLE;
            cnt      <= '0;
            fv_valid <= 1'b0;
            rx_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fv_len = len;

`ifdef FV_RX_ERRCHK_EN
  logic [LEN_W:0] wcount;
  logic           count_bad;
  logic           proto_bad;

  assign wcount    = {1'b0, wbase} + (LEN_W+1)'(1);
  assign count_bad = eos && (wcount != words_for(lenv));
  assign proto_bad = (state == IDLE && !sos) ||
                     (state == RECV && sos) ||
                     (state == FULL) ||
                     (we && count_bad);

  always_ff @(posedge clk) begin
    if (reset)
      rx_err <= 1'b0;
    else if (accept && proto_bad)
      rx_err <= 1'b1;
  end
`else
  assign rx_err = 1'b0;
`endif

endmodule

// File: tb/tb_edge_pe_fv_rx.sv
// Directed bench for edge_pe_fv_rx; rx_err expectations follow
// FV_RX_ERRCHK_EN.
module tb_edge_pe_fv_rx;
  import edge_pe_fv_rx_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [TAG_W-1:0]    my_tag;
  FV_bank_CNTL2Edge_PE fv_in;
  logic [LEN_W-1:0]    num_fv;
  logic [IDX_W-1:0]    rd_idx;
  logic [7:0]          rd_data;
  logic                fv_valid;
  logic [LEN_W-1:0]    fv_len;
  logic                fv_release;
  logic                rx_ready;
  logic                rx_err;

  int errors = 0;
  int checks = 0;

`ifdef FV_RX_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  edge_pe_fv_rx dut (
    .clk        (clk),
    .reset      (reset),
    .my_tag     (my_tag),
    .fv_in      (fv_in),
    .num_fv     (num_fv),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .fv_valid   (fv_valid),
    .fv_len     (fv_len),
    .fv_release (fv_release),
    .rx_ready   (rx_ready),
    .rx_err     (rx_err)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [TAG_W-1:0] tag, input logic s,
                      input logic e, input logic [15:0] d);
    fv_in.valid   = 1'b1;
    fv_in.sos     = s;
    fv_in.eos     = e;
    fv_in.PE_tag  = tag;
    fv_in.FV_data = d;
    @(posedge clk);
    #1;
    fv_in.valid = 1'b0;
    fv_in.sos   = 1'b0;
    fv_in.eos   = 1'b0;
  endtask

  task automatic release_buf();
    fv_release = 1'b1;
    @(posedge clk);
    #1;
    fv_release = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (fv_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %0b want 0", fv_valid);
    end
    checks++;
    if (fv_len !== 5'd0) begin
      errors++; $display("FAIL rst_len got %0d want 0", fv_len);
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %0b want 1", rx_ready);
    end
    checks++;
    if (rx_err !== 1'b0) begin
      errors++; $display("FAIL rst_err got %0b want 0", rx_err);
    end
  endtask

  task automatic test_multi_word();
    num_fv = 5'd5;
    send(2'd2, 1'b1, 1'b0, 16'h0201);
    checks++;
    if (rx_ready !== 1'b0 || fv_valid !== 1'b0) begin
      errors++;
      $display("FAIL mw_recv ready=%0b valid=%0b want 0 0",
               rx_ready, fv_valid);
    end
    num_fv = 5'd0;
    send(2'd2, 1'b0, 1'b0, 16'h0403);
    checks++;
    if (fv_valid !== 1'b0) begin
      errors++; $display("FAIL mw_early got %0b want 0", fv_valid);
    end
    send(2'd2, 1'b0, 1'b1, 16'h0005);
    checks++;
    if (fv_valid !== 1'b1) begin
      errors++; $display("FAIL mw_valid got %0b want 1", fv_valid);
    end
    checks++;
    if (fv_len !== 5'd5) begin
      errors++; $display("FAIL mw_len got %0d want 5", fv_len);
    end
    checks++;
    if (rx_err !== 1'b0) begin
      errors++; $display("FAIL mw_err got %0b want 0", rx_err);
    end
    for (int i = 0; i < 5; i++) begin
      rd_idx = IDX_W'(i);
      #1;
      checks++;
      if (rd_data !== 8'(i + 1)) begin
        errors++;
        $display("FAIL mw_byte%0d got %h want %h", i, rd_data, 8'(i + 1));
      end
    end
    release_buf();
    checks++;
    if (rx_ready !== 1'b1 || fv_valid !== 1'b0) begin
      errors++;
      $display("FAIL mw_release ready=%0b valid=%0b want 1 0",
               rx_ready, fv_valid);
    end
  endtask

  task automatic test_single_word();
    num_fv = 5'd2;
    send(2'd2, 1'b1, 1'b1, 16'hBBAA);
    checks++;
    if (fv_valid !== 1'b1 || fv_len !== 5'd2) begin
      errors++;
      $display("FAIL sw_full valid=%0b len=%0d want 1 2", fv_valid, fv_len);
    end
    rd_idx = 4'd0;
    #1;
    checks++;
    if (rd_data !== 8'hAA) begin
      errors++; $display("FAIL sw_byte0 got %h want aa", rd_data);
    end
    rd_idx = 4'd1;
    #1;
    checks++;
    if (rd_data !== 8'hBB) begin
      errors++; $display("FAIL sw_byte1 got %h want bb", rd_data);
    end
    checks++;
    if (rx_err !== 1'b0) begin
      errors++; $display("FAIL sw_err got %0b want 0", rx_err);
    end
    release_buf();
  endtask

  task automatic test_interleave();
    num_fv = 5'd4;
    send(2'd2, 1'b1, 1'b0, 16'h2211);
    send(2'd1, 1'b1, 1'b0, 16'hEEEE);
    send(2'd1, 1'b0, 1'b0, 16'hDDDD);
    send(2'd2, 1'b0, 1'b1, 16'h4433);
    send(2'd1, 1'b0, 1'b1, 16'hFFFF);
    checks++;
    if (fv_valid !== 1'b1 || fv_len !== 5'd4) begin
      errors++;
      $display("FAIL il_full valid=%0b len=%0d want 1 4", fv_valid, fv_len);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = IDX_W'(i);
      #1;
      checks++;
      if (rd_data !== 8'(8'h11 * (i + 1))) begin
        errors++;
        $display("FAIL il_byte%0d got %h want %h",
                 i, rd_data, 8'(8'h11 * (i + 1)));
      end
    end
    checks++;
    if (rx_err !== 1'b0) begin
      errors++; $display("FAIL il_err got %0b want 0", rx_err);
    end
  endtask

  task automatic test_full_drop();
    num_fv = 5'd2;
    send(2'd2, 1'b1, 1'b1, 16'h9999);
    rd_idx = 4'd0;
    #1;
    checks++;
    if (rd_data !== 8'h11 || fv_len !== 5'd4 || fv_valid !== 1'b1) begin
      errors++;
      $display("FAIL fd_hold byte=%h len=%0d valid=%0b want 11 4 1",
               rd_data, fv_len, fv_valid);
    end
    checks++;
    if (rx_err !== ERR_EXP) begin
      errors++; $display("FAIL fd_err got %0b want %0b", rx_err, ERR_EXP);
    end
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("FAIL fd_ready got %0b want 0", rx_ready);
    end
    fv_release = 1'b1;
    send(2'd2, 1'b1, 1'b0, 16'h8888);
    fv_release = 1'b0;
    checks++;
    if (rx_ready !== 1'b1 || fv_valid !== 1'b0) begin
      errors++;
      $display("FAIL fd_release ready=%0b valid=%0b want 1 0",
               rx_ready, fv_valid);
    end
    rd_idx = 4'd0;
    #1;
    checks++;
    if (rd_data !== 8'h11) begin
      errors++; $display("FAIL fd_race got %h want 11", rd_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    num_fv = 5'd8;
    send(2'd2, 1'b1, 1'b0, 16'h0A09);
    send(2'd2, 1'b0, 1'b0, 16'h0C0B);
    do_reset();
    checks++;
    if (fv_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_idle valid=%0b ready=%0b want 0 1",
               fv_valid, rx_ready);
    end
    num_fv = 5'd3;
    send(2'd2, 1'b1, 1'b0, 16'h3130);
    send(2'd2, 1'b0, 1'b1, 16'h7732);
    checks++;
    if (fv_valid !== 1'b1 || fv_len !== 5'd3) begin
      errors++;
      $display("FAIL rm_full valid=%0b len=%0d want 1 3", fv_valid, fv_len);
    end
    for (int i = 0; i < 3; i++) begin
      rd_idx = IDX_W'(i);
      #1;
      checks++;
      if (rd_data !== 8'(8'h30 + i)) begin
        errors++;
        $display("FAIL rm_byte%0d got %h want %h", i, rd_data, 8'(8'h30 + i));
      end
    end
    // Odd length: the upper byte of the last word must not land.
    rd_idx = 4'd3;
    #1;
    checks++;
    if (rd_data !== 8'h0C) begin
      errors++; $display("FAIL rm_oddhi got %h want 0c", rd_data);
    end
    checks++;
    if (rx_err !== 1'b0) begin
      errors++; $display("FAIL rm_err got %0b want 0", rx_err);
    end
    release_buf();
  endtask

  task automatic test_eos_mismatch();
    num_fv = 5'd6;
    send(2'd2, 1'b1, 1'b0, 16'h0201);
    send(2'd2, 1'b0, 1'b1, 16'h0403);
    checks++;
    if (fv_valid !== 1'b1 || fv_len !== 5'd6) begin
      errors++;
      $display("FAIL em_full valid=%0b len=%0d want 1 6", fv_valid, fv_len);
    end
    checks++;
    if (rx_err !== ERR_EXP) begin
      errors++; $display("FAIL em_err got %0b want %0b", rx_err, ERR_EXP);
    end
    release_buf();
  endtask

  task automatic test_max_len();
    do_reset();
    num_fv = 5'd16;
    for (int k = 0; k < 9; k++) begin
      if (k == 8)
        send(2'd2, 1'b0, 1'b1, 16'h5555);
      else
        send(2'd2, k == 0, 1'b0, {8'(8'h81 + 2 * k), 8'(8'h80 + 2 * k)});
    end
    checks++;
    if (fv_valid !== 1'b1 || fv_len !== 5'd16) begin
      errors++;
      $display("FAIL mx_full valid=%0b len=%0d want 1 16", fv_valid, fv_len);
    end
    for (int i = 0; i < 16; i += 15) begin
      rd_idx = IDX_W'(i);
      #1;
      checks++;
      if (rd_data !== 8'(8'h80 + i)) begin
        errors++;
        $display("FAIL mx_byte%0d got %h want %h", i, rd_data, 8'(8'h80 + i));
      end
    end
    checks++;
    if (rx_err !== ERR_EXP) begin
      errors++; $display("FAIL mx_err got %0b want %0b", rx_err, ERR_EXP);
    end
    release_buf();
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL mx_release got %0b want 1", rx_ready);
    end
  endtask

  initial begin
    reset      = 1'b1;
    my_tag     = 2'd2;
    fv_in      = '0;
    num_fv     = '0;
    rd_idx     = '0;
    fv_release = 1'b0;
    test_reset();
    test_multi_word();
    test_single_word();
    test_interleave();
    test_full_drop();
    test_reset_mid();
    test_eos_mismatch();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_pe_fv_rx.md
EDGE_PE_FV_RX -- requirements
Module: edge_pe_fv_rx

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 my_tag  input  $clog2(`Num_Edge_PE)  static PE index; only words with matching PE_tag are accepted.
REQ-004 fv_in  input  FV_bank_CNTL2Edge_PE  stream word: valid, sos, eos, PE_tag, FV_data[`FV_bandwidth-1:0] (16b, two 8b features: [7:0] = even feature, [15:8] = odd feature).
REQ-005 num_fv  input  $clog2(`Max_FV_num)+1  feature count of the vector in flight; sampled on accepted sos.
REQ-006 rd_idx  input  $clog2(`Max_FV_num)  consumer feature read index.
REQ-007 rd_data  output  8  feature byte at rd_idx, combinational from buffer.
REQ-008 fv_valid  output  1  complete vector held in buffer.
REQ-009 fv_len  output  $clog2(`Max_FV_num)+1  latched num_fv of held vector.
REQ-010 fv_release  input  1  single-cycle pulse from consumer; frees buffer.
REQ-011 rx_ready  output  1  buffer can accept a new vector; scheduler must not issue a bank request for this PE while low.
REQ-012 rx_err  output  1  sticky protocol error (present only with FV_RX_ERRCHK_EN, else tied 0).

Function
REQ-013 FSM states IDLE, RECV, FULL; encoded as 2-bit enum.
REQ-014 Accept = fv_in.valid && fv_in.PE_tag==my_tag; non-matching words ignored in all states.
REQ-015 IDLE: accept with sos&&eos -> write word 0, latch num_fv, go FULL; accept with sos only -> write word 0, word counter=1, go RECV; accept without sos -> ignored (error, REQ-025).
REQ-016 RECV: each accept writes word at counter, counter+1; accept with eos -> go FULL.
REQ-017 Word k writes feature 2k from [7:0] and feature 2k+1 from [15:8]; if num_fv odd, last word writes only feature num_fv-1, upper byte discarded.
REQ-018 Writes with feature index >= `Max_FV_num discarded (no wrap).
REQ-019 FULL: fv_valid=1, fv_len=latched num_fv; buffer contents stable; matching words dropped.
REQ-020 fv_release in FULL -> IDLE next cycle; fv_release in IDLE/RECV ignored.
REQ-021 rx_ready=1 only in IDLE; fv_valid registered, asserted cycle after eos accept (1-cycle latency).
REQ-022 fv_release and accepted sos in same cycle while FULL: release wins, word dropped (rx_ready was low).
REQ-023 rd_data for rd_idx >= fv_len returns stored byte, undefined content; consumer must bound by fv_len.

Reset
REQ-024 reset: state=IDLE, counter=0, fv_valid=0, fv_len=0, rx_ready=1, rx_err=0; buffer contents not cleared; reset mid-RECV discards partial vector.

Configuration
REQ-025 FV_RX_ERRCHK_EN defined: rx_err set (sticky until reset) on accept-without-sos in IDLE, accept-with-sos in RECV (restarts vector at word 0), accept in FULL, or eos word count != ceil(num_fv/2); undefined: no checker logic, rx_err=0, sos in RECV still restarts.

Structure
REQ-026 FV_bank_CNTL2Edge_PE, `Max_FV_num, `Num_Edge_PE, `FV_bandwidth from shared sys_defs package; FSM enum local.
REQ-027 One sub-module fv_rx_buf (byte-addressed register buffer, dual-byte write, single read port); FSM and counter in top.

Verification
REQ-028 my_tag=2, num_fv=5, words 0x0201,0x0403,0x0005 (sos first, eos last) tag 2 -> fv_valid 1 cycle after eos, fv_len=5, rd_data[0..4]=1..5.
REQ-029 num_fv=2, single word sos&eos 0xBBAA -> FULL, rd_data[0]=0xAA, [1]=0xBB.
REQ-030 Interleaved tag 1 and tag 2 streams, my_tag=2 -> only tag 2 bytes stored, tag 1 no effect.
REQ-031 FULL, new tag-2 sos arrives -> dropped, buffer unchanged, rx_err=1 with macro, 0 without; fv_release -> IDLE, rx_ready=1.
REQ-032 reset asserted after second word of 4-word vector -> IDLE, fv_valid=0; next full vector received correctly.
REQ-033 With macro: eos after 2 words with num_fv=6 -> rx_err=1, FULL entered.
